// File: rtl/sd_spi_host_cmd.sv
// SPI-mode SD host command engine: power-up preamble, 6-byte command framing
// with hardware CRC7, R1 polling with Ncr limit, optional 4-byte R3/R7 tail.
module sd_spi_host_cmd #(
  parameter int CLK_DIV    = 4,
  parameter int RESP_WAIT  = 8,
  parameter int INIT_BYTES = 10
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        init_start,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_long,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        resp_timeout,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic [2:0]  dbg_state
);

  localparam int BYTE_MAX0 = (INIT_BYTES > RESP_WAIT) ? INIT_BYTES : RESP_WAIT;
  localparam int BYTE_MAX  = (BYTE_MAX0 > 6) ? BYTE_MAX0 : 6;
  localparam int BW        = $clog2(BYTE_MAX + 1);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] INIT_LAST = BW'(INIT_BYTES - 1);
  localparam logic [BW-1:0] WAIT_LAST = BW'(RESP_WAIT - 1);
  localparam logic [BW-1:0] CMD_LAST  = BW'(5);
  localparam logic [BW-1:0] EXT_LAST  = BW'(3);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_CMD  = 3'd2,
    ST_WAIT = 3'd3,
    ST_EXT  = 3'd4,
    ST_TAIL = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;   // 0 = sclk low phase, 1 = high phase
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [47:0]   sh_q, sh_d;         // MOSI shifter, refills with ones
  logic [7:0]    rx_q, rx_d;
  logic          long_q, long_d;
  logic [7:0]    r1_q, r1_d;
  logic [31:0]   ext_q, ext_d;
  logic          tmo_q, tmo_d;

  logic        active, rise, fall, byte_end;
  logic [47:0] frame;

  // CRC7 (x^7 + x^3 + 1, init 0) over the 40 command/argument bits
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign frame = {2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};

  assign active   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign rise     = active && !phase_q && (div_q == DIV_LAST);
  assign fall     = active &&  phase_q && (div_q == DIV_LAST);
  assign byte_end = fall && (bit_q == 3'd7);

  // State register
  always_ff @(posedge clk_50) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; init wins over a simultaneous cmd_start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (init_start) state_d = ST_INIT;
               else if (cmd_start) state_d = ST_CMD;
      ST_INIT: if (byte_end && byte_q == INIT_LAST) state_d = ST_DONE;
      ST_CMD:  if (byte_end && byte_q == CMD_LAST) state_d = ST_WAIT;
      ST_WAIT: if (byte_end) begin
                 if (!rx_q[7])                   state_d = long_q ? ST_EXT : ST_TAIL;
                 else if (byte_q == WAIT_LAST)   state_d = ST_TAIL;
               end
      ST_EXT:  if (byte_end && byte_q == EXT_LAST) state_d = ST_TAIL;
      ST_TAIL: if (byte_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state and datapath flops
  always_comb begin
    cmd_busy     = (state_q != ST_IDLE);
    cmd_done     = (state_q == ST_DONE);
    resp_r1      = r1_q;
    resp_ext     = ext_q;
    resp_timeout = tmo_q;
    spi_sclk     = sclk_q;
    spi_mosi     = sh_q[47];
    spi_cs_n     = cs_n_q;
    dbg_state    = state_q;
  end

  // Datapath: bit engine, byte counting, start capture and result registers
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    long_d  = long_q;
    r1_d    = r1_q;
    ext_d   = ext_q;
    tmo_d   = tmo_q;

    if (state_q == ST_IDLE) begin
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
      byte_d  = '0;
      if (!init_start && cmd_start) begin
        // cs_n drops now so the first low phase doubles as CS setup time
        sh_d   = frame;
        cs_n_d = 1'b0;
        long_d = resp_long;
        r1_d   = 8'hFF;
        ext_d  = '0;
        tmo_d  = 1'b0;
      end
    end

    if (active) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      if (rise) begin
        phase_d = 1'b1;
        sclk_d  = 1'b1;
        rx_d    = {rx_q[6:0], spi_miso};
      end
      if (fall) begin
        phase_d = 1'b0;
        sclk_d  = 1'b0;
        sh_d    = {sh_q[46:0], 1'b1};
        bit_d   = bit_q + 3'd1;
      end
      if (byte_end) begin
        byte_d = (state_d != state_q) ? '0 : byte_q + BW'(1);
        if (state_q == ST_WAIT) begin
          if (!rx_q[7]) begin
            r1_d = rx_q;
          end else if (byte_q == WAIT_LAST) begin
            tmo_d = 1'b1;
            r1_d  = 8'hFF;
          end
        end
        if (state_q == ST_EXT)  ext_d  = {ext_q[23:0], rx_q};
        if (state_q == ST_TAIL) cs_n_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset aborts at once with CS high and sclk low
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '1;
      rx_q    <= 8'hFF;
      long_q  <= 1'b0;
      r1_q    <= 8'hFF;
      ext_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      long_q  <= long_d;
      r1_q    <= r1_d;
      ext_q   <= ext_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_host_cmd.sv
// Directed bench for sd_spi_host_cmd with a behavioural SPI-mode card model.
// Handshake: init_start / cmd_start are single-cycle pulses, accepted only
// while cmd_busy=0; completion is the one-cycle cmd_done pulse.
module tb_sd_spi_host_cmd;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        init_start, cmd_start, resp_long;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_busy, cmd_done, resp_timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b1;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] exp_q[$];

  // card model / monitor state (written only by the monitor block)
  int         rise_cnt = 0, rise_cs_hi = 0, mosi_lo_cs_hi = 0;
  int         cs_fall_cnt = 0, byte_cnt = 0, rx_bits = 0, done_cnt = 0, rd_idx = 0;
  logic [7:0] rx_sh = 8'hFF, tx_sh = 8'hFF;
  logic       sclk_prev = 1'b0, cs_prev = 1'b1;
  logic [7:0] obs_mem [0:31];
  // reply bytes (written only by the stimulus block)
  logic [7:0] reply_mem [0:7];
  int         reply_len = 0;

  sd_spi_host_cmd #(.CLK_DIV(4), .RESP_WAIT(8), .INIT_BYTES(10)) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .init_start  (init_start),
    .cmd_start   (cmd_start),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .resp_long   (resp_long),
    .cmd_busy    (cmd_busy),
    .cmd_done    (cmd_done),
    .resp_r1     (resp_r1),
    .resp_ext    (resp_ext),
    .resp_timeout(resp_timeout),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs_n    (spi_cs_n),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #10 clk_50 = ~clk_50;

  // card model: captures MOSI on sclk rise, shifts MISO on sclk fall,
  // starts replying after the 6 command bytes; counts bus events
  always @(negedge clk_50) begin
    if (!spi_cs_n && cs_prev) begin
      cs_fall_cnt++;
      rx_bits  = 0;
      byte_cnt = 0;
      rd_idx   = 0;
    end
    if (spi_sclk && !sclk_prev) begin
      rise_cnt++;
      if (spi_cs_n) begin
        rise_cs_hi++;
        if (!spi_mosi) mosi_lo_cs_hi++;
      end else begin
        rx_sh = {rx_sh[6:0], spi_mosi};
        rx_bits++;
        if (rx_bits == 8) begin
          if (byte_cnt < 32) obs_mem[byte_cnt] = rx_sh;
          byte_cnt++;
          rx_bits = 0;
        end
      end
    end
    if (!spi_sclk && sclk_prev && !spi_cs_n) begin
      if (rx_bits == 0) begin
        if (byte_cnt >= 6 && rd_idx < reply_len) begin
          tx_sh = reply_mem[rd_idx];
          rd_idx++;
        end else begin
          tx_sh = 8'hFF;
        end
      end
      spi_miso = tx_sh[7];
      tx_sh    = {tx_sh[6:0], 1'b1};
    end
    if (spi_cs_n) spi_miso = 1'b1;
    if (cmd_done) done_cnt++;
    sclk_prev = spi_sclk;
    cs_prev   = spi_cs_n;
  end

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_reply(input logic [39:0] b, input int n);
    for (int i = 0; i < n; i++) reply_mem[i] = b[8*(n-1-i) +: 8];
    reply_len = n;
  endtask

  task automatic pulse_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng);
    @(negedge clk_50);
    cmd_index = idx;
    cmd_arg   = arg;
    resp_long = lng;
    cmd_start = 1'b1;
    @(negedge clk_50);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    if (done_cnt == start) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (6) @(negedge clk_50);
    check_eq({tag, "_done_pulses"}, done_cnt - start, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] f);
    for (int i = 0; i < 6; i++) exp_q.push_back(f[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("%s_b%0d", tag, i), {24'd0, obs_mem[i]}, {24'd0, e});
    end
  endtask

  // directed stimulus
  initial begin
    int r0, h0, c0, d0;
    int ff_cnt;
    reset_n    = 1'b0;
    init_start = 1'b0;
    cmd_start  = 1'b0;
    resp_long  = 1'b0;
    cmd_index  = '0;
    cmd_arg    = '0;
    repeat (3) @(negedge clk_50);

    // reset state
    check_eq("rst_sclk", spi_sclk, 1'b0);
    check_eq("rst_cs_n", spi_cs_n, 1'b1);
    check_eq("rst_mosi", spi_mosi, 1'b1);
    check_eq("rst_busy", cmd_busy, 1'b0);
    check_eq("rst_done", cmd_done, 1'b0);
    check_eq("rst_r1",   resp_r1, 8'hFF);
    check_eq("rst_ext",  resp_ext, 32'd0);
    check_eq("rst_tmo",  resp_timeout, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);

    // power-up preamble
    r0 = rise_cnt; h0 = rise_cs_hi; c0 = cs_fall_cnt;
    init_start = 1'b1;
    @(negedge clk_50);
    init_start = 1'b0;
    check_eq("init_busy", cmd_busy, 1'b1);
    wait_done("init", 2000);
    check_eq("init_rises",     rise_cnt - r0, 32'd80);
    check_eq("init_rises_csh", rise_cs_hi - h0, 32'd80);
    check_eq("init_mosi_low",  mosi_lo_cs_hi, 32'd0);
    check_eq("init_cs_fall",   cs_fall_cnt - c0, 32'd0);
    check_eq("init_r1",        resp_r1, 8'hFF);
    check_eq("init_busy_end",  cmd_busy, 1'b0);

    // CMD0, card replies FF FF 01
    set_reply(40'h00_00_FF_FF_01, 3);
    pulse_cmd(6'd0, 32'h0, 1'b0);
    check_eq("cmd0_busy", cmd_busy, 1'b1);
    wait_done("cmd0", 3000);
    check_frame("cmd0", 48'h40_00_00_00_00_95);
    check_eq("cmd0_r1",    resp_r1, 8'h01);
    check_eq("cmd0_tmo",   resp_timeout, 1'b0);
    check_eq("cmd0_bytes", byte_cnt, 32'd10);
    check_eq("cmd0_cs_n",  spi_cs_n, 1'b1);

    // init and cmd together: only the preamble, results untouched
    r0 = rise_cnt; c0 = cs_fall_cnt;
    @(negedge clk_50);
    init_start = 1'b1;
    cmd_start  = 1'b1;
    @(negedge clk_50);
    init_start = 1'b0;
    cmd_start  = 1'b0;
    wait_done("both", 2000);
    check_eq("both_rises",   rise_cnt - r0, 32'd80);
    check_eq("both_cs_fall", cs_fall_cnt - c0, 32'd0);
    check_eq("both_r1_hold", resp_r1, 8'h01);

    // CMD8 with R7 tail
    set_reply(40'h01_00_00_01_AA, 5);
    pulse_cmd(6'd8, 32'h0000_01AA, 1'b1);
    wait_done("cmd8", 3000);
    check_frame("cmd8", 48'h48_00_00_01_AA_87);
    check_eq("cmd8_r1",    resp_r1, 8'h01);
    check_eq("cmd8_ext",   resp_ext, 32'h0000_01AA);
    check_eq("cmd8_tmo",   resp_timeout, 1'b0);
    check_eq("cmd8_bytes", byte_cnt, 32'd12);

    // timeout: MISO stays high
    set_reply(40'h0, 0);
    pulse_cmd(6'd55, 32'h0, 1'b1);
    wait_done("tmo", 4000);
    check_frame("tmo", 48'h77_00_00_00_00_65);
    ff_cnt = 0;
    for (int i = 6; i < 15; i++) if (obs_mem[i] == 8'hFF) ff_cnt++;
    check_eq("tmo_poll_ff", ff_cnt, 32'd9);
    check_eq("tmo_bytes",   byte_cnt, 32'd15);
    check_eq("tmo_flag",    resp_timeout, 1'b1);
    check_eq("tmo_r1",      resp_r1, 8'hFF);
    check_eq("tmo_ext",     resp_ext, 32'd0);

    // cmd_start during a command is dropped
    c0 = cs_fall_cnt;
    set_reply(40'h00_00_00_00_01, 1);
    pulse_cmd(6'd0, 32'h0, 1'b0);
    repeat (150) @(negedge clk_50);
    cmd_index = 6'd17;
    cmd_arg   = 32'h1234_5678;
    cmd_start = 1'b1;
    @(negedge clk_50);
    cmd_start = 1'b0;
    wait_done("coll", 3000);
    repeat (300) @(negedge clk_50);
    check_eq("coll_frames", cs_fall_cnt - c0, 32'd1);
    check_frame("coll", 48'h40_00_00_00_00_95);
    check_eq("coll_r1", resp_r1, 8'h01);

    // reset during command byte 3
    d0 = done_cnt;
    pulse_cmd(6'd8, 32'h0000_01AA, 1'b0);
    r0 = 0;
    while (byte_cnt != 3 && r0 < 2000) begin
      @(negedge clk_50);
      r0++;
    end
    check_eq("rst_mid_reached", byte_cnt, 32'd3);
    repeat (5) @(negedge clk_50);
    reset_n = 1'b0;
    @(posedge clk_50);
    #1;
    check_eq("rst_mid_cs_n", spi_cs_n, 1'b1);
    check_eq("rst_mid_sclk", spi_sclk, 1'b0);
    check_eq("rst_mid_busy", cmd_busy, 1'b0);
    @(negedge clk_50);
    reset_n = 1'b1;
    repeat (800) @(negedge clk_50);
    check_eq("rst_mid_no_done", done_cnt - d0, 32'd0);
    check_eq("rst_mid_r1", resp_r1, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
